// File: rtl/vga_timing_gen.sv
// Raster timing source: pixel/line counters, run/stop FSM, and a two-stage
// output pipeline (coordinates one cycle ahead of active-video and sync).
module vga_timing_gen #(
    parameter int unsigned p_H_ACT    = 800,
    parameter int unsigned p_H_FP     = 56,
    parameter int unsigned p_H_SYNC   = 120,
    parameter int unsigned p_H_BP     = 64,
    parameter int unsigned p_V_ACT    = 600,
    parameter int unsigned p_V_FP     = 37,
    parameter int unsigned p_V_SYNC   = 6,
    parameter int unsigned p_V_BP     = 23,
    parameter logic        p_HS_POL   = 1'b1,
    parameter logic        p_VS_POL   = 1'b1
) (
    input  logic        VGA_CLK,
    input  logic        RST_N,
    input  logic        RUN,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_IF_RGBEN_1,
    output logic [10:0] CURRENT_X,
    output logic [10:0] CURRENT_Y,
    output logic        FRAME_START,
    output logic [7:0]  FRAME_CNT
);

    localparam int unsigned CW    = 11;
    localparam int unsigned H_TOT = p_H_SYNC + p_H_BP + p_H_ACT + p_H_FP;
    localparam int unsigned V_TOT = p_V_SYNC + p_V_BP + p_V_ACT + p_V_FP;

    localparam logic [CW-1:0] H_LAST    = CW'(H_TOT - 1);
    localparam logic [CW-1:0] V_LAST    = CW'(V_TOT - 1);
    localparam logic [CW-1:0] H_SYNC_E  = CW'(p_H_SYNC);
    localparam logic [CW-1:0] V_SYNC_E  = CW'(p_V_SYNC);
    localparam logic [CW-1:0] H_ACT_BEG = CW'(p_H_SYNC + p_H_BP);
    localparam logic [CW-1:0] H_ACT_END = CW'(p_H_SYNC + p_H_BP + p_H_ACT);
    localparam logic [CW-1:0] V_ACT_BEG = CW'(p_V_SYNC + p_V_BP);
    localparam logic [CW-1:0] V_ACT_END = CW'(p_V_SYNC + p_V_BP + p_V_ACT);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    // Counters are 11 bits wide; larger rasters cannot be represented.
    if (H_TOT > 2047 || V_TOT > 2047) begin : g_size_check
        $error("vga_timing_gen: H/V total exceeds 11-bit counter range");
    end

    logic [1:0]    state, state_nxt;
    logic [CW-1:0] h_cnt, v_cnt;
    logic          live_c, h_last_c, eof_c, act_c;
    logic          hs_s1, vs_s1, en_s1;

    // Counters advance whenever not idle, and already on the IDLE->RUN cycle.
    always_comb begin
        live_c   = (state != S_IDLE) || RUN;
        h_last_c = (h_cnt == H_LAST);
        eof_c    = h_last_c && (v_cnt == V_LAST);
        act_c    = live_c
                   && (h_cnt >= H_ACT_BEG) && (h_cnt < H_ACT_END)
                   && (v_cnt >= V_ACT_BEG) && (v_cnt < V_ACT_END);
    end

    always_ff @(posedge VGA_CLK or negedge RST_N) begin
        if (!RST_N) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (RUN) state_nxt = S_RUN;
            S_RUN:   if (!RUN) state_nxt = S_DRAIN;
            S_DRAIN: begin
                if (RUN)        state_nxt = S_RUN;
                else if (eof_c) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge VGA_CLK or negedge RST_N) begin
        if (!RST_N) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (live_c) begin
            if (h_last_c) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CW'(1);
            end else begin
                h_cnt <= h_cnt + CW'(1);
            end
        end else begin
            h_cnt <= '0;
            v_cnt <= '0;
        end
    end

    // Stage 1: coordinates, frame-start pulse, and sync/enable pre-registers.
    always_ff @(posedge VGA_CLK or negedge RST_N) begin
        if (!RST_N) begin
            CURRENT_X   <= '0;
            CURRENT_Y   <= '0;
            FRAME_START <= 1'b0;
            hs_s1       <= 1'b0;
            vs_s1       <= 1'b0;
            en_s1       <= 1'b0;
        end else begin
            CURRENT_X   <= act_c ? h_cnt - H_ACT_BEG : '0;
            CURRENT_Y   <= act_c ? v_cnt - V_ACT_BEG : '0;
            FRAME_START <= live_c && (h_cnt == '0) && (v_cnt == '0);
            hs_s1       <= live_c && (h_cnt < H_SYNC_E);
            vs_s1       <= live_c && (v_cnt < V_SYNC_E);
            en_s1       <= act_c;
        end
    end

    // Stage 2: sync and active-video, one cycle behind the coordinates.
    always_ff @(posedge VGA_CLK or negedge RST_N) begin
        if (!RST_N) begin
            VGA_HS         <= ~p_HS_POL;
            VGA_VS         <= ~p_VS_POL;
            VGA_IF_RGBEN_1 <= 1'b0;
        end else begin
            VGA_HS         <= hs_s1 ? p_HS_POL : ~p_HS_POL;
            VGA_VS         <= vs_s1 ? p_VS_POL : ~p_VS_POL;
            VGA_IF_RGBEN_1 <= en_s1;
        end
    end

    always_ff @(posedge VGA_CLK or negedge RST_N) begin
        if (!RST_N)                FRAME_CNT <= '0;
        else if (live_c && eof_c)  FRAME_CNT <= FRAME_CNT + 8'd1;
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a shrunken raster (9x6 frame), both sync polarities.
module tb_vga_timing_gen;

    localparam int HA = 4, HF = 2, HS = 2, HB = 1;
    localparam int VA = 3, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam int HOFF = HS + HB;
    localparam int VOFF = VS + VB;

    logic        VGA_CLK = 1'b0;
    logic        RST_N   = 1'b0;
    logic        run     = 1'b0;

    logic        hs_p, vs_p, en_p, fs_p;
    logic [10:0] x_p, y_p;
    logic [7:0]  fc_p;
    logic        hs_n, vs_n, en_n, fs_n;
    logic [10:0] x_n, y_n;
    logic [7:0]  fc_n;

    vga_timing_gen #(
        .p_H_ACT(HA), .p_H_FP(HF), .p_H_SYNC(HS), .p_H_BP(HB),
        .p_V_ACT(VA), .p_V_FP(VF), .p_V_SYNC(VS), .p_V_BP(VB),
        .p_HS_POL(1'b1), .p_VS_POL(1'b1)
    ) dut_p (
        .VGA_CLK(VGA_CLK), .RST_N(RST_N), .RUN(run),
        .VGA_HS(hs_p), .VGA_VS(vs_p), .VGA_IF_RGBEN_1(en_p),
        .CURRENT_X(x_p), .CURRENT_Y(y_p),
        .FRAME_START(fs_p), .FRAME_CNT(fc_p)
    );

    vga_timing_gen #(
        .p_H_ACT(HA), .p_H_FP(HF), .p_H_SYNC(HS), .p_H_BP(HB),
        .p_V_ACT(VA), .p_V_FP(VF), .p_V_SYNC(VS), .p_V_BP(VB),
        .p_HS_POL(1'b0), .p_VS_POL(1'b0)
    ) dut_n (
        .VGA_CLK(VGA_CLK), .RST_N(RST_N), .RUN(run),
        .VGA_HS(hs_n), .VGA_VS(vs_n), .VGA_IF_RGBEN_1(en_n),
        .CURRENT_X(x_n), .CURRENT_Y(y_n),
        .FRAME_START(fs_n), .FRAME_CNT(fc_n)
    );

    always #5 VGA_CLK = ~VGA_CLK;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: position within the frame plus running/stop-requested flags.
    int m_pos, m_fc;
    bit m_running, m_stop_req;
    bit m_act_d, m_hs_d, m_vs_d;
    bit e_en, e_hs, e_vs, e_fs;
    int e_x, e_y;

    task automatic model_reset();
        m_pos = 0; m_fc = 0; m_running = 0; m_stop_req = 0;
        m_act_d = 0; m_hs_d = 0; m_vs_d = 0;
        e_en = 0; e_hs = 0; e_vs = 0; e_fs = 0; e_x = 0; e_y = 0;
    endtask

    task automatic model_step();
        bit live, act, eof;
        int h, v;
        live = m_running || run;
        h = m_pos % HT;
        v = m_pos / HT;
        eof = (m_pos == FT - 1);
        e_en = m_act_d; e_hs = m_hs_d; e_vs = m_vs_d;
        act = live && h >= HOFF && h < HOFF + HA && v >= VOFF && v < VOFF + VA;
        e_x = act ? h - HOFF : 0;
        e_y = act ? v - VOFF : 0;
        e_fs = live && (m_pos == 0);
        m_act_d = act;
        m_hs_d = live && (h < HS);
        m_vs_d = live && (v < VS);
        if (live) begin
            m_pos = (m_pos + 1) % FT;
            if (eof) m_fc = (m_fc + 1) % 256;
        end
        if (!m_running) begin
            m_running = run;
            m_stop_req = 0;
        end else if (run) begin
            m_stop_req = 0;
        end else if (!m_stop_req) begin
            m_stop_req = 1;
        end else if (eof) begin
            m_running = 0;
            m_stop_req = 0;
        end
    endtask

    task automatic step();
        @(posedge VGA_CLK);
        #1;
        model_step();
    endtask

    task automatic check_model();
        chk("hs_p", hs_p, e_hs);
        chk("vs_p", vs_p, e_vs);
        chk("hs_n", hs_n, !e_hs);
        chk("vs_n", vs_n, !e_vs);
        chk("en_p", en_p, e_en);
        chk("en_n", en_n, e_en);
        chk("x", x_p, e_x);
        chk("y", y_p, e_y);
        chk("x_n", x_n, e_x);
        chk("y_n", y_n, e_y);
        chk("fs", fs_p, e_fs);
        chk("fs_n", fs_n, e_fs);
        chk("fc", fc_p, m_fc);
        chk("fc_n", fc_n, m_fc);
    endtask

    typedef struct {
        int n;
        int hs, vs, en, fs, x, y, fc;
    } vec_t;

    vec_t tbl[14];

    initial begin
        int idx, cnt, fc_before, period;

        // Hand-derived first frame: sample after edge n, RUN=1 from before edge 1.
        tbl[0]  = '{1,  0, 0, 0, 1, 0, 0, 0};
        tbl[1]  = '{2,  1, 1, 0, 0, 0, 0, 0};
        tbl[2]  = '{3,  1, 1, 0, 0, 0, 0, 0};
        tbl[3]  = '{4,  0, 1, 0, 0, 0, 0, 0};
        tbl[4]  = '{11, 1, 0, 0, 0, 0, 0, 0};
        tbl[5]  = '{23, 0, 0, 1, 0, 1, 0, 0};
        tbl[6]  = '{25, 0, 0, 1, 0, 3, 0, 0};
        tbl[7]  = '{26, 0, 0, 1, 0, 0, 0, 0};
        tbl[8]  = '{27, 0, 0, 0, 0, 0, 0, 0};
        tbl[9]  = '{33, 0, 0, 1, 0, 2, 1, 0};
        tbl[10] = '{42, 0, 0, 1, 0, 2, 2, 0};
        tbl[11] = '{54, 0, 0, 0, 0, 0, 0, 1};
        tbl[12] = '{55, 0, 0, 0, 1, 0, 0, 1};
        tbl[13] = '{56, 1, 1, 0, 0, 0, 0, 1};

        model_reset();
        RST_N = 1'b0;
        repeat (3) @(posedge VGA_CLK);
        #1;
        chk("rst_hs_p", hs_p, 0);
        chk("rst_hs_n", hs_n, 1);
        chk("rst_vs_n", vs_n, 1);
        chk("rst_en", en_p, 0);
        chk("rst_fc", fc_p, 0);
        RST_N = 1'b1;
        run = 1'b1;

        idx = 0;
        for (int n = 1; n <= 56; n++) begin
            step();
            if (idx < 14 && tbl[idx].n == n) begin
                chk($sformatf("tbl%0d_hs", n), hs_p, tbl[idx].hs);
                chk($sformatf("tbl%0d_vs", n), vs_p, tbl[idx].vs);
                chk($sformatf("tbl%0d_en", n), en_p, tbl[idx].en);
                chk($sformatf("tbl%0d_fs", n), fs_p, tbl[idx].fs);
                chk($sformatf("tbl%0d_x", n), x_p, tbl[idx].x);
                chk($sformatf("tbl%0d_y", n), y_p, tbl[idx].y);
                chk($sformatf("tbl%0d_fc", n), fc_p, tbl[idx].fc);
                idx++;
            end
        end

        // Stop mid-frame: the frame completes, then everything parks idle.
        cnt = 0;
        while (m_pos != 3 * HT + 1 && cnt < 200) begin step(); check_model(); cnt++; end
        chk("stop_reach", cnt < 200 ? 1 : 0, 1);
        run = 1'b0;
        fc_before = m_fc;
        cnt = 0;
        while (m_running && cnt < 200) begin step(); check_model(); cnt++; end
        chk("drain_done", cnt < 200 ? 1 : 0, 1);
        repeat (3) begin step(); check_model(); end
        chk("drain_fc", fc_p, (fc_before + 1) % 256);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_hs", hs_p, 0);
            chk("idle_vs", vs_p, 0);
            chk("idle_en", en_p, 0);
            chk("idle_x", x_p, 0);
            chk("idle_fs", fs_p, 0);
            chk("idle_fc", fc_p, (fc_before + 1) % 256);
        end

        // RUN 1->0->1 inside a frame: frame period unchanged.
        run = 1'b1;
        cnt = 0;
        while (!fs_p && cnt < 200) begin step(); check_model(); cnt++; end
        chk("fs_first", fs_p, 1);
        period = 0;
        do begin
            if (period == 10) run = 1'b0;
            if (period == 15) run = 1'b1;
            step(); check_model(); period++;
        end while (!fs_p && period < 200);
        chk("frame_period", period, FT);

        // Asynchronous reset in the active area: outputs drop with no clock edge.
        cnt = 0;
        while (m_pos != 4 * HT + 5 && cnt < 200) begin step(); check_model(); cnt++; end
        #2;
        RST_N = 1'b0;
        #1;
        chk("arst_hs_p", hs_p, 0);
        chk("arst_vs_p", vs_p, 0);
        chk("arst_hs_n", hs_n, 1);
        chk("arst_vs_n", vs_n, 1);
        chk("arst_en", en_p, 0);
        chk("arst_x", x_p, 0);
        chk("arst_y", y_p, 0);
        chk("arst_fs", fs_p, 0);
        chk("arst_fc", fc_p, 0);
        run = 1'b0;
        model_reset();
        @(posedge VGA_CLK);
        #1;
        RST_N = 1'b1;

        // Randomized RUN against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 29) == 0) run = ~run;
            step();
            check_model();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
